pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of each data word.
REQ-002 The block SHALL have parameter NUM_DATA, default 2: number of data words per entry (e.g. ALU result, memory data).
REQ-003 The block SHALL have parameter RD_W, default 5: destination register index width.
REQ-004 The block SHALL have parameter CTRL_W, default 3: control field width (e.g. result-select).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 flush  input  1  synchronous kill of all held entries.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_data  input  NUM_DATA*DATA_W  packed data words; word k occupies bits [k*DATA_W +: DATA_W].
REQ-011 in_rd  input  RD_W  destination register index.
REQ-012 in_ctrl  input  CTRL_W  control field.
REQ-013 out_valid  output  1  output entry present.
REQ-014 out_ready  input  1  downstream accepts the entry.
REQ-015 out_data, out_rd, out_ctrl  output  same widths as inputs  held entry payload.
REQ-016 count  output  2  entries held (0..2).

Function
REQ-017 The block SHALL store at most two entries: a main register (drives outputs) and a skid register.
REQ-018 An input transfer SHALL occur on an edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-019 in_ready SHALL be a registered signal equal to 1 exactly when the skid register is empty; it SHALL NOT combinationally depend on out_ready.
REQ-020 out_valid SHALL equal the main valid bit; out_data/out_rd/out_ctrl SHALL come directly from main registers (no combinational path from inputs).
REQ-021 Latency SHALL be one cycle: an entry accepted into an empty stage appears on outputs the next cycle.
REQ-022 Main empty, input transfer: entry loads main.
REQ-023 Main full, output transfer, input transfer, skid empty: new entry loads main (full throughput, one entry per cycle).
REQ-024 Main full, no output transfer, input transfer: new entry loads skid; in_ready falls next cycle.
REQ-025 Skid full and output transfer: skid entry moves to main, skid empties, in_ready rises next cycle.
REQ-026 Main full, output transfer, no input, skid empty: main valid clears.
REQ-027 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush.
REQ-028 flush SHALL have priority over all transfers: at the edge, both valid bits clear, any concurrent input is discarded, count becomes 0, in_ready becomes 1.
REQ-029 Payload registers SHALL load only on their own load condition; payload of invalid entries is don't-care except after reset.
REQ-030 count SHALL equal main valid + skid valid, registered.
REQ-031 The block SHALL be correct for any NUM_DATA >= 1, DATA_W >= 1, RD_W >= 1, CTRL_W >= 1.

Reset
REQ-032 On rst assertion, immediately and regardless of clk: both valid bits 0, out_valid 0, in_ready 1, count 0, out_data/out_rd/out_ctrl all zero, skid payload zero.
REQ-033 Reset mid-operation SHALL discard held entries; the first edge after rst deasserts SHALL accept input normally.

Verification
REQ-034 Streaming: out_ready=1, inputs rd=1,2,3,4 on consecutive cycles -> out_rd 1,2,3,4 one cycle later, count stays 1, in_ready stays 1.
REQ-035 Backpressure: out_ready=0, send rd=7 then rd=9 -> count 2, in_ready 0, out_rd 7 held; raise out_ready -> out_rd 9 next cycle, then out_valid 0, no loss.
REQ-036 Flush with full stage plus concurrent in_valid (rd=5) -> next cycle count 0, out_valid 0, in_ready 1; rd=5 never appears.
REQ-037 Async reset: assert rst between edges with count 2 -> out_valid 0, count 0, out_data 0 before next edge.
REQ-038 Parameter sweep: NUM_DATA=3, DATA_W=8, in_data=0x0A0B0C -> out_data 0x0A0B0C, word 0 = 0x0C.
REQ-039 Random valid/ready stress vs. FIFO scoreboard, 10000 cycles -> order preserved, in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry pipeline register with a skid buffer.
//
// The main register drives the outputs directly, so there is no combinational
// path from any input to the payload outputs. The skid register catches the one
// entry that can arrive while the main entry is stalled, which allows in_ready
// to be a registered signal with no combinational dependence on out_ready.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   flush      synchronous kill of all held entries (beats every transfer)
//   in_valid   upstream entry present
//   in_ready   registered; high exactly when the skid register is empty
//   in_data    NUM_DATA packed words, word k at [k*DATA_W +: DATA_W]
//   in_rd      destination register index
//   in_ctrl    control field
//   out_valid  main register holds an entry
//   out_ready  downstream accepts the entry
//   out_data/out_rd/out_ctrl  main register payload
//   count      number of entries held (0..2), registered
module pipe_stage_skid #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 2,
  parameter int RD_W     = 5,
  parameter int CTRL_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]            in_rd,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]            out_rd,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [1:0]                 count
);

  localparam int PAY_W = NUM_DATA*DATA_W + RD_W + CTRL_W;

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [PAY_W-1:0] main_pay_q, main_pay_d;
  logic [PAY_W-1:0] skid_pay_q, skid_pay_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       count_q, count_d;

  logic [PAY_W-1:0] in_pay;
  logic             in_xfer;
  logic             out_xfer;

  assign in_pay   = {in_data, in_rd, in_ctrl};
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_pay_d   = main_pay_q;
    skid_pay_d   = skid_pay_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so no new entry can arrive; only a drain moves data.
      if (out_xfer) begin
        main_pay_d   = skid_pay_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q) begin
      if (in_xfer) begin
        main_pay_d   = in_pay;
        main_valid_d = 1'b1;
      end
    end else if (out_xfer) begin
      if (in_xfer) begin
        main_pay_d = in_pay;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      // Main is stalled: park the new entry in the skid register.
      skid_pay_d   = in_pay;
      skid_valid_d = 1'b1;
    end

    in_ready_d = ~skid_valid_d;
    count_d    = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_pay_q   <= '0;
      skid_pay_q   <= '0;
      in_ready_q   <= 1'b1;
      count_q      <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_pay_q   <= main_pay_d;
      skid_pay_q   <= skid_pay_d;
      in_ready_q   <= in_ready_d;
      count_q      <= count_d;
    end
  end

  assign in_ready                     = in_ready_q;
  assign out_valid                    = main_valid_q;
  assign {out_data, out_rd, out_ctrl} = main_pay_q;
  assign count                        = count_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random testbench for pipe_stage_skid.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [4:0]  in_rd;
  logic [2:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic [2:0]  out_ctrl;
  logic [1:0]  count;

  // Second instance with a non-default geometry.
  logic        p_flush;
  logic        p_in_valid;
  logic        p_in_ready;
  logic [23:0] p_in_data;
  logic [4:0]  p_in_rd;
  logic [2:0]  p_in_ctrl;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [23:0] p_out_data;
  logic [4:0]  p_out_rd;
  logic [2:0]  p_out_ctrl;
  logic [1:0]  p_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .count(count)
  );

  pipe_stage_skid #(.DATA_W(8), .NUM_DATA(3), .RD_W(5), .CTRL_W(3)) dut3 (
    .clk(clk), .rst(rst), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_data(p_in_data), .in_rd(p_in_rd), .in_ctrl(p_in_ctrl),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_data(p_out_data), .out_rd(p_out_rd), .out_ctrl(p_out_ctrl),
    .count(p_count)
  );

  task automatic drive_in(input logic v, input logic [4:0] rd);
    in_valid = v;
    in_rd    = rd;
    in_data  = {32'hD000_0000 | 32'(rd), 32'hA000_0000 | 32'(rd)};
    in_ctrl  = rd[2:0];
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; drive_in(1'b0, 5'd0);
    p_flush = 1'b0; p_in_valid = 1'b0; p_in_data = '0; p_in_rd = '0;
    p_in_ctrl = '0; p_out_ready = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b ready=%b count=%0d, want 0 1 0",
               out_valid, in_ready, count);
    end
    checks++;
    if (out_data !== 64'd0 || out_rd !== 5'd0 || out_ctrl !== 3'd0) begin
      errors++;
      $display("FAIL reset_payload: got data=%h rd=%0d ctrl=%0d, want zeros",
               out_data, out_rd, out_ctrl);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    @(negedge clk);
    out_ready = 1'b1;
    drive_in(1'b1, 5'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_rd !== 5'(i) || count !== 2'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got valid=%b rd=%0d count=%0d ready=%b, want 1 %0d 1 1",
                 i, out_valid, out_rd, count, in_ready, i);
      end
      checks++;
      if (out_data !== {32'hD000_0000 | 32'(i), 32'hA000_0000 | 32'(i)}) begin
        errors++;
        $display("FAIL stream_data_%0d: got %h", i, out_data);
      end
      if (i < 4) drive_in(1'b1, 5'(i + 1));
      else       drive_in(1'b0, 5'd0);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: got valid=%b count=%0d, want 0 0", out_valid, count);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    drive_in(1'b1, 5'd7);
    @(negedge clk);
    drive_in(1'b1, 5'd9);
    @(negedge clk);
    // Offer rd=11 while full; it must wait until space frees up.
    drive_in(1'b1, 5'd11);
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0 || out_rd !== 5'd7 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: got count=%0d ready=%b rd=%0d valid=%b, want 2 0 7 1",
               count, in_ready, out_rd, out_valid);
    end
    @(negedge clk);
    checks++;
    if (count !== 2'd2 || out_rd !== 5'd7) begin
      errors++;
      $display("FAIL bp_hold: got count=%0d rd=%0d, want 2 7", count, out_rd);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_rd !== 5'd9 || count !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_skid_move: got rd=%0d count=%0d ready=%b, want 9 1 1",
               out_rd, count, in_ready);
    end
    @(negedge clk);
    drive_in(1'b0, 5'd0);
    checks++;
    if (out_rd !== 5'd11 || out_valid !== 1'b1 || count !== 2'd1) begin
      errors++;
      $display("FAIL bp_late_entry: got rd=%0d valid=%b count=%0d, want 11 1 1",
               out_rd, out_valid, count);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      errors++;
      $display("FAIL bp_empty: got valid=%b count=%0d, want 0 0", out_valid, count);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0;
    drive_in(1'b1, 5'd1);
    @(negedge clk);
    drive_in(1'b1, 5'd2);
    @(negedge clk);
    flush = 1'b1;
    drive_in(1'b1, 5'd5);
    @(negedge clk);
    flush = 1'b0;
    drive_in(1'b0, 5'd0);
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: got count=%0d valid=%b ready=%b, want 0 0 1",
               count, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      errors++;
      $display("FAIL flush_no_ghost: got valid=%b rd=%0d, want valid 0", out_valid, out_rd);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0;
    drive_in(1'b1, 5'd3);
    @(negedge clk);
    drive_in(1'b1, 5'd4);
    @(negedge clk);
    drive_in(1'b0, 5'd0);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== 64'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got valid=%b count=%0d data=%h ready=%b, want 0 0 0 1",
               out_valid, count, out_data, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_in(1'b1, 5'd6);
    @(negedge clk);
    drive_in(1'b0, 5'd0);
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd6 || count !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_accept: got valid=%b rd=%0d count=%0d, want 1 6 1",
               out_valid, out_rd, count);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_param_sweep();
    @(negedge clk);
    p_in_valid  = 1'b1;
    p_in_data   = 24'h0A0B0C;
    p_in_rd     = 5'd17;
    p_in_ctrl   = 3'd5;
    p_out_ready = 1'b0;
    @(negedge clk);
    p_in_valid = 1'b0;
    checks++;
    if (p_out_valid !== 1'b1 || p_out_data !== 24'h0A0B0C || p_out_rd !== 5'd17 ||
        p_out_ctrl !== 3'd5) begin
      errors++;
      $display("FAIL param_payload: got valid=%b data=%h rd=%0d ctrl=%0d, want 1 0a0b0c 17 5",
               p_out_valid, p_out_data, p_out_rd, p_out_ctrl);
    end
    checks++;
    if (p_out_data[7:0] !== 8'h0C || p_out_data[23:16] !== 8'h0A) begin
      errors++;
      $display("FAIL param_word0: got word0=%h word2=%h, want 0c 0a",
               p_out_data[7:0], p_out_data[23:16]);
    end
    p_out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random_stress();
    logic [71:0] q[$];
    logic [71:0] exp_pay;
    logic        rdy_before;
    int          n_in = 0;
    int          n_out = 0;
    int          e0 = errors;
    q.delete();
    drive_in(1'b0, 5'd0);
    flush = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 10000; c++) begin
      // Model-side checks of registered state before driving new inputs.
      if (errors - e0 < 10) begin
        checks++;
        if (count !== 2'(q.size()) || out_valid !== (q.size() != 0) ||
            in_ready !== (q.size() < 2)) begin
          errors++;
          $display("FAIL stress_state c=%0d: got count=%0d valid=%b ready=%b, want size=%0d",
                   c, count, out_valid, in_ready, q.size());
        end
        if (q.size() != 0) begin
          exp_pay = q[0];
          checks++;
          if ({out_data, out_rd, out_ctrl} !== exp_pay) begin
            errors++;
            $display("FAIL stress_order c=%0d: got %h, want %h",
                     c, {out_data, out_rd, out_ctrl}, exp_pay);
          end
        end
      end
      rdy_before = in_ready;
      out_ready  = ($urandom_range(0, 9) < 6);
      #1;
      checks++;
      if (in_ready !== rdy_before) begin
        errors++;
        $display("FAIL stress_comb_ready c=%0d: in_ready moved %b -> %b with out_ready",
                 c, rdy_before, in_ready);
      end
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = {$urandom, $urandom};
      in_rd    = 5'($urandom);
      in_ctrl  = 3'($urandom);
      flush    = ($urandom_range(0, 63) == 0);
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
        if (in_valid && in_ready) begin
          q.push_back({in_data, in_rd, in_ctrl});
          n_in++;
        end
      end
      @(negedge clk);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (n_out < 1000) begin
      errors++;
      $display("FAIL stress_traffic: got %0d outputs (in %0d), want >= 1000", n_out, n_in);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_param_sweep();
    test_random_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
